// File: rtl/pipeline_control_unit.sv
// Main control for a 5-stage MIPS pipeline.
// Decodes the ID instruction and carries the EX/MEM/WB control bundles through the
// ID/EX, EX/MEM and MEM/WB control registers. Inserts a bubble on a load-use hazard,
// holds EX while a multi-cycle MUL runs, and flushes IF/ID for taken branches and jumps.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   valid_i      IF/ID holds a real instruction
//   op_i         opcode
//   funct_i      function field (R-type only)
//   rs_i, rt_i   source register fields of the ID instruction
//   branch_eq_i  rs == rt comparator result from ID
//   jump_o       J in ID, PC takes the jump target
//   branch_o     taken BEQ in ID
//   stall_o      hold PC and IF/ID
//   flush_o      zero IF/ID on the next edge
//   ex_ctrl_o    {ALUop, ALUsrc, RegDst} from ID/EX
//   mem_ctrl_o   {MEM_cs, MEM_we} from EX/MEM
//   wb_ctrl_o    {Reg_we, MemToReg} from MEM/WB
//   mul_busy_o   a MUL is occupying EX
//   illegal_o    sticky undefined opcode/funct flag
module pipeline_control_unit #(
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MUL_LAT   = 3,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         op_i,
  input  logic [5:0]         funct_i,
  input  logic [REG_AW-1:0]  rs_i,
  input  logic [REG_AW-1:0]  rt_i,
  input  logic               branch_eq_i,
  output logic               jump_o,
  output logic               branch_o,
  output logic               stall_o,
  output logic               flush_o,
  output logic [ALUOP_W+1:0] ex_ctrl_o,
  output logic [1:0]         mem_ctrl_o,
  output logic [1:0]         wb_ctrl_o,
  output logic               mul_busy_o,
  output logic               illegal_o
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnMul = 6'b011000;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluMul = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(4);

  localparam bit         MulStalls = (MUL_LAT > 1);
  localparam logic [3:0] MulCnt    = 4'(MUL_LAT - 1);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_cs;
    logic               mem_we;
    logic               reg_we;
    logic               mem_to_reg;
  } ctrl_t;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  ctrl_t             dec;
  logic              dec_illegal;
  ctrl_t             idex_q, idex_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  logic [3:0]        exmem_q, exmem_d;  // {cs, we, reg_we, mem_to_reg}
  logic [1:0]        memwb_q, memwb_d;  // {reg_we, mem_to_reg}
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              mul_busy, luse, stall;

  // ID decode; a non-valid slot always decodes to a bubble.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    unique case (op_i)
      OpRtype: begin
        dec.reg_dst = 1'b1;
        dec.reg_we  = 1'b1;
        unique case (funct_i)
          FnAdd:   dec.alu_op = AluAdd;
          FnSub:   dec.alu_op = AluSub;
          FnMul:   dec.alu_op = AluMul;
          FnAnd:   dec.alu_op = AluAnd;
          FnOr:    dec.alu_op = AluOr;
          default: begin
            dec         = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OpAddi: begin
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
      end
      OpLw: begin
        dec.alu_src    = 1'b1;
        dec.mem_cs     = 1'b1;
        dec.reg_we     = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OpSw: begin
        dec.alu_src = 1'b1;
        dec.mem_cs  = 1'b1;
        dec.mem_we  = 1'b1;
      end
      OpBeq, OpJ: dec = '0;
      default:    dec_illegal = 1'b1;
    endcase
    if (!valid_i) begin
      dec         = '0;
      dec_illegal = 1'b0;
    end
  end

  always_comb begin
    mul_busy = (state_q == StBusy);
    luse     = HAZARD_EN & idex_q.mem_cs & ~idex_q.mem_we & valid_i &
               ((idex_rt_q == rs_i) | (idex_rt_q == rt_i));
    stall    = luse | mul_busy;

    // A running MUL holds ID/EX, which takes priority over the load-use bubble.
    idex_d    = idex_q;
    idex_rt_d = idex_rt_q;
    if (!mul_busy) begin
      if (luse) begin
        idex_d    = '0;
        idex_rt_d = '0;
      end else begin
        idex_d    = dec;
        idex_rt_d = valid_i ? rt_i : '0;
      end
    end

    exmem_d = mul_busy ? 4'b0000
                       : {idex_q.mem_cs, idex_q.mem_we, idex_q.reg_we, idex_q.mem_to_reg};
    memwb_d = exmem_q[1:0];

    // BUSY is entered on the edge a MUL is loaded into ID/EX, so it covers the first
    // MUL_LAT-1 EX cycles; the final EX cycle runs with the FSM back in IDLE.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (MulStalls && (idex_d.alu_op == AluMul)) begin
          state_d = StBusy;
          cnt_d   = MulCnt;
        end
      end
      StBusy: begin
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    illegal_d = illegal_q | dec_illegal;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idex_q    <= '0;
      idex_rt_q <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      idex_rt_q <= idex_rt_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign stall_o    = stall;
  assign mul_busy_o = mul_busy;
  assign jump_o     = valid_i & ~stall & (op_i == OpJ);
  assign branch_o   = valid_i & ~stall & (op_i == OpBeq) & branch_eq_i;
  assign flush_o    = jump_o | branch_o;
  assign ex_ctrl_o  = {idex_q.alu_op, idex_q.alu_src, idex_q.reg_dst};
  assign mem_ctrl_o = exmem_q[3:2];
  assign wb_ctrl_o  = memwb_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: a directed vector table with hand-derived outputs,
// then randomized instruction streams, both checked against a behavioural model of the
// pipeline. Two instances: default (MUL_LAT=3, hazards on) and MUL_LAT=1 with hazards off.
module tb_pipeline_control_unit;

  typedef struct packed {
    logic [2:0] alu;
    logic       src, dst, cs, we, rwe, m2r;
  } bnd_t;

  typedef struct {
    bnd_t       ex;
    logic [4:0] ex_rt;
    bnd_t       mem;
    bnd_t       wb;
    int         mul_left;  // stall cycles still owed to the MUL in EX
    bit         ill;
  } mdl_t;

  typedef struct {
    bit         rst_n;
    bit         valid;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         beq;
  } in_t;

  typedef struct packed {
    logic       jump, branch, stall, flush;
    logic [4:0] ex;
    logic [1:0] mem, wb;
    logic       busy, ill;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  localparam logic [5:0] OpR = 6'b000000, OpJ = 6'b000010, OpBeq = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] FnAdd = 6'b100000, FnSub = 6'b100010, FnMul = 6'b011000;
  localparam logic [5:0] FnAnd = 6'b100100, FnOr = 6'b100101;
  localparam logic [4:0] ExAdd = 5'b00001, ExImm = 5'b00010, ExMul = 5'b01001;

  logic       clk;
  logic       rst, valid, beq;
  logic [5:0] op, funct;
  logic [4:0] rs, rt;

  logic       jump_a, branch_a, stall_a, flush_a, busy_a, ill_a;
  logic [4:0] ex_a;
  logic [1:0] mem_a, wb_a;
  logic       jump_b, branch_b, stall_b, flush_b, busy_b, ill_b;
  logic [4:0] ex_b;
  logic [1:0] mem_b, wb_b;

  int   checks = 0;
  int   errors = 0;
  mdl_t sa, sb;
  vec_t tbl[$];

  pipeline_control_unit dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct_i(funct),
    .rs_i(rs), .rt_i(rt), .branch_eq_i(beq),
    .jump_o(jump_a), .branch_o(branch_a), .stall_o(stall_a), .flush_o(flush_a),
    .ex_ctrl_o(ex_a), .mem_ctrl_o(mem_a), .wb_ctrl_o(wb_a),
    .mul_busy_o(busy_a), .illegal_o(ill_a)
  );

  pipeline_control_unit #(.MUL_LAT(1), .HAZARD_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct_i(funct),
    .rs_i(rs), .rt_i(rt), .branch_eq_i(beq),
    .jump_o(jump_b), .branch_o(branch_b), .stall_o(stall_b), .flush_o(flush_b),
    .ex_ctrl_o(ex_b), .mem_ctrl_o(mem_b), .wb_ctrl_o(wb_b),
    .mul_busy_o(busy_b), .illegal_o(ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bnd_t m_dec(in_t i);
    bnd_t b = '0;
    if (!i.valid) return b;
    case (i.op)
      OpR: case (i.funct)
        FnAdd: b = '{alu: 3'd0, src: 0, dst: 1, cs: 0, we: 0, rwe: 1, m2r: 0};
        FnSub: b = '{alu: 3'd1, src: 0, dst: 1, cs: 0, we: 0, rwe: 1, m2r: 0};
        FnMul: b = '{alu: 3'd2, src: 0, dst: 1, cs: 0, we: 0, rwe: 1, m2r: 0};
        FnAnd: b = '{alu: 3'd3, src: 0, dst: 1, cs: 0, we: 0, rwe: 1, m2r: 0};
        FnOr:  b = '{alu: 3'd4, src: 0, dst: 1, cs: 0, we: 0, rwe: 1, m2r: 0};
        default: b = '0;
      endcase
      OpAddi: b = '{alu: 3'd0, src: 1, dst: 0, cs: 0, we: 0, rwe: 1, m2r: 0};
      OpLw:   b = '{alu: 3'd0, src: 1, dst: 0, cs: 1, we: 0, rwe: 1, m2r: 1};
      OpSw:   b = '{alu: 3'd0, src: 1, dst: 0, cs: 1, we: 1, rwe: 0, m2r: 0};
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic bit m_ill(in_t i);
    if (!i.valid) return 1'b0;
    if (i.op == OpR)
      return !(i.funct inside {FnAdd, FnSub, FnMul, FnAnd, FnOr});
    return !(i.op inside {OpAddi, OpLw, OpSw, OpBeq, OpJ});
  endfunction

  function automatic mdl_t m_reset();
    mdl_t s;
    s.ex = '0; s.ex_rt = '0; s.mem = '0; s.wb = '0; s.mul_left = 0; s.ill = 1'b0;
    return s;
  endfunction

  function automatic bit m_luse(mdl_t s, in_t i, bit haz);
    return haz && s.ex.cs && !s.ex.we && i.valid && (s.ex_rt == i.rs || s.ex_rt == i.rt);
  endfunction

  function automatic out_t m_out(mdl_t s, in_t i, bit haz);
    out_t o;
    bit   busy = (s.mul_left > 0);
    bit   stl  = busy || m_luse(s, i, haz);
    o.stall  = stl;
    o.busy   = busy;
    o.jump   = i.valid && !stl && (i.op == OpJ);
    o.branch = i.valid && !stl && (i.op == OpBeq) && i.beq;
    o.flush  = o.jump || o.branch;
    o.ex     = {s.ex.alu, s.ex.src, s.ex.dst};
    o.mem    = {s.mem.cs, s.mem.we};
    o.wb     = {s.wb.rwe, s.wb.m2r};
    o.ill    = s.ill;
    return o;
  endfunction

  function automatic mdl_t m_next(mdl_t s, in_t i, bit haz, int lat);
    mdl_t n = s;
    bit   busy = (s.mul_left > 0);
    bit   luse = m_luse(s, i, haz);
    if (!i.rst_n) return m_reset();
    n.wb  = s.mem;
    n.mem = busy ? bnd_t'('0) : s.ex;
    if (busy) begin
      n.mul_left = s.mul_left - 1;
    end else begin
      n.ex       = luse ? bnd_t'('0) : m_dec(i);
      n.ex_rt    = (luse || !i.valid) ? 5'd0 : i.rt;
      n.mul_left = (n.ex.alu == 3'd2) ? lat - 1 : 0;
    end
    n.ill = s.ill | m_ill(i);
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic in_t mk_in(bit v, logic [5:0] o, logic [5:0] f, logic [4:0] s,
                                logic [4:0] t, bit b, bit r);
    in_t i;
    i.valid = v; i.op = o; i.funct = f; i.rs = s; i.rt = t; i.beq = b; i.rst_n = r;
    return i;
  endfunction

  function automatic in_t r_ins(logic [5:0] f, logic [4:0] s, logic [4:0] t);
    return mk_in(1, OpR, f, s, t, 0, 1);
  endfunction

  function automatic in_t i_ins(logic [5:0] o, logic [4:0] s, logic [4:0] t, bit b);
    return mk_in(1, o, 6'd0, s, t, b, 1);
  endfunction

  function automatic out_t mk_out(logic [4:0] ex, logic [1:0] mem, logic [1:0] wb, bit stl,
                                  bit busy, bit j, bit br, bit ill);
    out_t o;
    o.ex = ex; o.mem = mem; o.wb = wb; o.stall = stl; o.busy = busy;
    o.jump = j; o.branch = br; o.flush = j | br; o.ill = ill;
    return o;
  endfunction

  task automatic row(input in_t i, input out_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %b required %b (jump,branch,stall,flush,ex,mem,wb,busy,ill)",
               name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    rst = i.rst_n; valid = i.valid; op = i.op; funct = i.funct;
    rs = i.rs; rt = i.rt; beq = i.beq;
  endtask

  // One cycle: drive after the edge, sample on the falling edge, then advance the model.
  task automatic step(input in_t i, input bit has_exp, input out_t exp_a, input string tag);
    out_t act_a, act_b;
    drive(i);
    @(negedge clk);
    act_a = {jump_a, branch_a, stall_a, flush_a, ex_a, mem_a, wb_a, busy_a, ill_a};
    act_b = {jump_b, branch_b, stall_b, flush_b, ex_b, mem_b, wb_b, busy_b, ill_b};
    if (has_exp) chk({tag, "_vec"}, act_a, exp_a);
    chk({tag, "_mdl_a"}, act_a, m_out(sa, i, 1'b1));
    chk({tag, "_mdl_b"}, act_b, m_out(sb, i, 1'b0));
    @(posedge clk);
    sa = m_next(sa, i, 1'b1, 3);
    sb = m_next(sb, i, 1'b0, 1);
    #1;
  endtask

  initial begin
    in_t  nop, z_in;
    out_t z;
    nop  = mk_in(0, OpR, 6'd0, 5'd0, 5'd0, 0, 1);
    z    = mk_out(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, then ADD -> ADDI with no hazards.
    row(nop,                        z);
    row(r_ins(FnAdd, 1, 3),         z);
    row(i_ins(OpAddi, 4, 5, 0),     mk_out(ExAdd, 0, 0, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(ExImm, 0, 0, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    // LW $2 then ADD using $2: one bubble.
    row(i_ins(OpLw, 1, 2, 0),       z);
    row(r_ins(FnAdd, 2, 3),         mk_out(ExImm, 0, 0, 1, 0, 0, 0, 0));
    row(r_ins(FnAdd, 2, 3),         mk_out(0, 2'b10, 0, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(ExAdd, 0, 2'b11, 0, 0, 0, 0, 0));
    row(nop,                        z);
    row(nop,                        mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    // MUL (3 cycles in EX) with ADDI waiting in ID.
    row(r_ins(FnMul, 1, 2),         z);
    row(i_ins(OpAddi, 6, 7, 0),     mk_out(ExMul, 0, 0, 1, 1, 0, 0, 0));
    row(i_ins(OpAddi, 6, 7, 0),     mk_out(ExMul, 0, 0, 1, 1, 0, 0, 0));
    row(i_ins(OpAddi, 6, 7, 0),     mk_out(ExMul, 0, 0, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(ExImm, 0, 0, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    // BEQ taken / not taken, J, and J with valid low.
    row(i_ins(OpBeq, 1, 1, 1),      mk_out(0, 0, 0, 0, 0, 0, 1, 0));
    row(i_ins(OpBeq, 1, 2, 0),      z);
    row(i_ins(OpJ, 0, 0, 0),        mk_out(0, 0, 0, 0, 0, 1, 0, 0));
    row(mk_in(0, OpJ, 0, 0, 0, 1, 1), z);
    // Taken BEQ held off while the MUL is busy.
    row(r_ins(FnMul, 3, 3),         z);
    row(i_ins(OpBeq, 1, 1, 1),      mk_out(ExMul, 0, 0, 1, 1, 0, 0, 0));
    row(i_ins(OpBeq, 1, 1, 1),      mk_out(ExMul, 0, 0, 1, 1, 0, 0, 0));
    row(i_ins(OpBeq, 1, 1, 1),      mk_out(ExMul, 0, 0, 0, 0, 0, 1, 0));
    row(nop,                        z);
    // Illegal opcode, then reset in the middle of a MUL.
    row(i_ins(6'b111111, 0, 0, 0),  mk_out(0, 0, 2'b10, 0, 0, 0, 0, 0));
    row(nop,                        mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    row(r_ins(FnMul, 1, 2),         mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    row(nop,                        mk_out(ExMul, 0, 0, 1, 1, 0, 0, 1));
    row(mk_in(0, OpR, 0, 0, 0, 0, 0), mk_out(ExMul, 0, 0, 1, 1, 0, 0, 1));
    row(nop,                        z);
    row(r_ins(FnAdd, 1, 2),         z);
    row(nop,                        mk_out(ExAdd, 0, 0, 0, 0, 0, 0, 0));

    // Power-up: hold reset for two edges before the model takes over.
    z_in = mk_in(0, OpR, 0, 0, 0, 0, 0);
    drive(z_in);
    repeat (2) @(posedge clk);
    #1;
    sa = m_reset();
    sb = m_reset();

    foreach (tbl[k]) step(tbl[k].i, 1'b1, tbl[k].e, $sformatf("row%0d", k));

    for (int n = 0; n < 3000; n++) begin
      in_t r;
      logic [5:0] o, f;
      o = OpR;
      f = FnAdd;
      case ($urandom_range(0, 11))
        0:  f = FnAdd;
        1:  f = FnSub;
        2:  f = FnMul;
        3:  f = FnAnd;
        4:  f = FnOr;
        5:  f = 6'b111111;
        6:  o = OpAddi;
        7:  o = OpLw;
        8:  o = OpSw;
        9:  o = OpBeq;
        10: o = OpJ;
        default: o = 6'(($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b010101);
      endcase
      if (o != OpR) f = 6'($urandom);
      r = mk_in($urandom_range(0, 9) < 8, o, f, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 49) != 0);
      step(r, 1'b0, z, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
